// File: rtl/screen_sequencer.sv
// OLED screen controller: sequences TITLE -> PLAY -> OVER -> TITLE on frame
// boundaries, owns the game-over hold timer and blink, and registers the pixel mux.
module screen_sequencer #(
  parameter int unsigned HOLD_FRAMES  = 180,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter logic [15:0] BG_COLOUR    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic        start_btn,
  input  logic        game_end,
  input  logic [15:0] title_data,
  input  logic [15:0] play_data,
  input  logic [15:0] over_data,
  output logic [15:0] oled_data,
  output logic [1:0]  screen,
  output logic        game_active,
  output logic [7:0]  frames_left
);

  typedef enum logic [1:0] {
    TITLE   = 2'd0,
    PLAY    = 2'd1,
    OVER    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_INIT  = 8'(HOLD_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 32'd1);

  state_t      state_r;
  logic        pending_r;
  logic [7:0]  frames_left_r;
  logic [7:0]  blink_cnt_r;
  logic        blink_phase_r;
  logic [15:0] oled_data_r;
  logic        game_active_r;

  logic        req_s;
  logic        advance_s;
  logic [15:0] pixel_s;

  // Qualifying request for the current screen; game_end only counts in PLAY.
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      TITLE:   req_s = start_btn;
      PLAY:    req_s = game_end;
      OVER:    req_s = start_btn;
      default: req_s = 1'b0;
    endcase
    advance_s = frame_begin & (pending_r | req_s);
  end

  // Pixel source select, registered into oled_data one edge later.
  always_comb begin
    pixel_s = BG_COLOUR;
    case (state_r)
      TITLE:   pixel_s = title_data;
      PLAY:    pixel_s = play_data;
      OVER: begin
        if (blink_phase_r) begin
          pixel_s = BG_COLOUR;
        end else begin
          pixel_s = over_data;
        end
      end
      default: pixel_s = BG_COLOUR;
    endcase
  end

  // Screen FSM with request latch, hold timer, blink and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= TITLE;
      pending_r     <= 1'b0;
      frames_left_r <= 8'd0;
      blink_cnt_r   <= 8'd0;
      blink_phase_r <= 1'b0;
      oled_data_r   <= BG_COLOUR;
      game_active_r <= 1'b0;
    end else begin
      oled_data_r <= pixel_s;
      case (state_r)
        TITLE: begin
          if (advance_s) begin
            state_r       <= PLAY;
            game_active_r <= 1'b1;
            pending_r     <= 1'b0;
          end else if (req_s) begin
            pending_r <= 1'b1;
          end
        end
        PLAY: begin
          if (advance_s) begin
            state_r       <= OVER;
            game_active_r <= 1'b0;
            pending_r     <= 1'b0;
            frames_left_r <= HOLD_INIT;
            blink_cnt_r   <= 8'd0;
            blink_phase_r <= 1'b0;
          end else if (req_s) begin
            pending_r <= 1'b1;
          end
        end
        OVER: begin
          // A skip wins over the timer; expiry on the same edge is one transition.
          if (advance_s || (frame_begin && frames_left_r == 8'd1)) begin
            state_r       <= TITLE;
            pending_r     <= 1'b0;
            frames_left_r <= 8'd0;
          end else if (frame_begin) begin
            frames_left_r <= frames_left_r - 8'd1;
          end else if (req_s) begin
            pending_r <= 1'b1;
          end
          if (frame_begin) begin
            if (blink_cnt_r == BLINK_LAST) begin
              blink_cnt_r   <= 8'd0;
              blink_phase_r <= ~blink_phase_r;
            end else begin
              blink_cnt_r <= blink_cnt_r + 8'd1;
            end
          end
        end
        default: begin
          state_r       <= TITLE;
          pending_r     <= 1'b0;
          frames_left_r <= 8'd0;
          blink_cnt_r   <= 8'd0;
          blink_phase_r <= 1'b0;
          game_active_r <= 1'b0;
        end
      endcase
    end
  end

  assign oled_data   = oled_data_r;
  assign screen      = state_r;
  assign game_active = game_active_r;
  assign frames_left = frames_left_r;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed self-checking bench for screen_sequencer (HOLD_FRAMES=5, BLINK_FRAMES=2).
module tb_screen_sequencer;

  localparam logic [15:0] BG    = 16'h001F;
  localparam logic [15:0] TITLE_PIX = 16'hF800;
  localparam logic [15:0] PLAY_PIX  = 16'h1234;
  localparam logic [15:0] OVER_PIX  = 16'h07E0;

  logic        clk;
  logic        reset;
  logic        frame_begin;
  logic        start_btn;
  logic        game_end;
  logic [15:0] title_data;
  logic [15:0] play_data;
  logic [15:0] over_data;
  logic [15:0] oled_data;
  logic [1:0]  screen;
  logic        game_active;
  logic [7:0]  frames_left;

  int checks = 0;
  int errors = 0;

  screen_sequencer #(
    .HOLD_FRAMES (5),
    .BLINK_FRAMES(2),
    .BG_COLOUR   (BG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_begin(frame_begin),
    .start_btn  (start_btn),
    .game_end   (game_end),
    .title_data (title_data),
    .play_data  (play_data),
    .over_data  (over_data),
    .oled_data  (oled_data),
    .screen     (screen),
    .game_active(game_active),
    .frames_left(frames_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold the given inputs for exactly one active edge.
  task automatic pulse(input logic s, input logic g, input logic f);
    start_btn   = s;
    game_end    = g;
    frame_begin = f;
    step(1);
    start_btn   = 1'b0;
    game_end    = 1'b0;
    frame_begin = 1'b0;
  endtask

  logic [15:0] blink_exp [1:4];

  initial begin
    blink_exp[1] = OVER_PIX;
    blink_exp[2] = BG;
    blink_exp[3] = BG;
    blink_exp[4] = OVER_PIX;

    reset = 1'b0; frame_begin = 1'b0; start_btn = 1'b0; game_end = 1'b0;
    title_data = TITLE_PIX; play_data = PLAY_PIX; over_data = OVER_PIX;

    step(2);
    chk("rst_screen", 16'(screen), 16'd0);
    chk("rst_oled", oled_data, BG);
    chk("rst_active", 16'(game_active), 16'd0);
    chk("rst_frames", 16'(frames_left), 16'd0);
    reset = 1'b1;
    step(1);
    chk("release_oled", oled_data, TITLE_PIX);

    // Start latched 10 cycles before the frame boundary.
    pulse(1'b1, 1'b0, 1'b0);
    step(9);
    chk("title_wait", 16'(screen), 16'd0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("play_screen", 16'(screen), 16'd1);
    chk("play_active", 16'(game_active), 16'd1);
    chk("play_old_pix", oled_data, TITLE_PIX);
    step(1);
    chk("play_pix", oled_data, PLAY_PIX);

    pulse(1'b1, 1'b0, 1'b1);
    chk("play_ignore_start", 16'(screen), 16'd1);

    // game_end one cycle after a boundary waits for the next one.
    pulse(1'b0, 1'b1, 1'b0);
    step(3);
    chk("play_wait", 16'(screen), 16'd1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("over_screen", 16'(screen), 16'd2);
    chk("over_frames", 16'(frames_left), 16'd5);
    chk("over_active", 16'(game_active), 16'd0);
    step(1);
    chk("over_pix0", oled_data, OVER_PIX);

    for (int k = 1; k <= 4; k++) begin
      pulse(1'b0, (k == 1), 1'b1);
      chk("hold_frames", 16'(frames_left), 16'(5 - k));
      chk("hold_screen", 16'(screen), 16'd2);
      step(1);
      chk("blink_pix", oled_data, blink_exp[k]);
    end
    pulse(1'b0, 1'b0, 1'b1);
    chk("expire_screen", 16'(screen), 16'd0);
    chk("expire_frames", 16'(frames_left), 16'd0);
    step(1);
    chk("expire_pix", oled_data, TITLE_PIX);

    pulse(1'b0, 1'b1, 1'b1);
    chk("title_ignore_end", 16'(screen), 16'd0);

    // Same-cycle requests, simultaneous game_end+start, then a skip.
    pulse(1'b1, 1'b0, 1'b1);
    chk("r2_play", 16'(screen), 16'd1);
    pulse(1'b1, 1'b1, 1'b1);
    chk("r2_over", 16'(screen), 16'd2);
    chk("r2_frames", 16'(frames_left), 16'd5);
    pulse(1'b0, 1'b0, 1'b1);
    chk("r2_dec", 16'(frames_left), 16'd4);
    pulse(1'b1, 1'b0, 1'b0);
    step(2);
    chk("skip_wait", 16'(screen), 16'd2);
    chk("skip_wait_frames", 16'(frames_left), 16'd4);
    pulse(1'b0, 1'b0, 1'b1);
    chk("skip_screen", 16'(screen), 16'd0);
    chk("skip_frames", 16'(frames_left), 16'd0);

    // Skip coincident with expiry: single transition, nothing left pending.
    pulse(1'b1, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) pulse(1'b0, 1'b0, 1'b1);
    chk("r3_frames1", 16'(frames_left), 16'd1);
    pulse(1'b1, 1'b0, 1'b1);
    chk("r3_screen", 16'(screen), 16'd0);
    chk("r3_frames", 16'(frames_left), 16'd0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("r3_no_extra", 16'(screen), 16'd0);

    // Reset mid-hold with a pending skip.
    pulse(1'b1, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("r4_frames", 16'(frames_left), 16'd4);
    pulse(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    chk("r4_rst_screen", 16'(screen), 16'd0);
    chk("r4_rst_frames", 16'(frames_left), 16'd0);
    chk("r4_rst_oled", oled_data, BG);
    step(2);
    reset = 1'b1;
    step(1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("r4_no_pending", 16'(screen), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
